// File: rtl/ctrl_mode_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_mode_arbiter_if
//  Purpose  : Request/grant and control-output bundle of ctrl_mode_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface ctrl_mode_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int MODE_W = 4
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]        req;
   logic [N_REQ*MODE_W-1:0] req_mode;
   logic [N_REQ-1:0]        gnt;
   logic [ID_W-1:0]         gnt_id;
   logic                    ctrl_enable;
   logic [MODE_W-1:0]       ctrl_mode;
   logic                    busy;
   logic                    done;
   logic                    timeout;

   // Arbiter side
   modport master (
      input  req, req_mode,
      output gnt, gnt_id, ctrl_enable, ctrl_mode, busy, done, timeout
   );

   // Requester side
   modport slave (
      output req, req_mode,
      input  gnt, gnt_id, ctrl_enable, ctrl_mode, busy, done, timeout
   );
endinterface
`default_nettype wire

// File: rtl/ctrl_mode_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_mode_arbiter
//  Purpose  : Round-robin owner arbitration of the shared enable/mode control
//             interface with break-before-make sequencing.
//             Optional macro CTRL_ARB_TIMEOUT_EN forces release after MAX_HOLD
//             enable cycles.
//  Revision : 1.0  initial release
// ============================================================================
module ctrl_mode_arbiter #(
   parameter int N_REQ    = 4,
   parameter int MODE_W   = 4,
   parameter int MIN_HOLD = 4,
   parameter int MAX_HOLD = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   ctrl_mode_arbiter_if.master bus
);
   localparam int c_ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int c_HOLD_W = $clog2(MAX_HOLD + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETUP   = 2'd1,
      ST_ACTIVE  = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t              r_state,  w_state_nxt;
   logic [N_REQ-1:0]    r_gnt,    w_gnt_nxt;
   logic [c_ID_W-1:0]   r_gnt_id, w_gnt_id_nxt;
   logic [c_ID_W-1:0]   r_last,   w_last_nxt;
   logic                r_enable, w_enable_nxt;
   logic [MODE_W-1:0]   r_mode,   w_mode_nxt;
   logic [c_HOLD_W-1:0] r_hold,   w_hold_nxt;
   logic                r_busy,   w_busy_nxt;
   logic                r_done,   w_done_nxt;
`ifdef CTRL_ARB_TIMEOUT_EN
   logic                r_timeout, w_timeout_nxt;
`endif

   logic                w_any;
   logic [c_ID_W-1:0]   w_pick;
   logic [c_ID_W-1:0]   w_cand;
   logic [MODE_W-1:0]   w_pick_mode;
   logic                w_to_hit;
   logic                w_rel;

   // Scan downward in distance so the closest requester after r_last wins.
   always_comb begin
      w_any  = 1'b0;
      w_pick = '0;
      w_cand = '0;
      for (int j = N_REQ; j >= 1; j--) begin
         w_cand = c_ID_W'((int'(r_last) + j) % N_REQ);
         if (bus.req[w_cand]) begin
            w_any  = 1'b1;
            w_pick = w_cand;
         end
      end
   end

   always_comb begin
      w_pick_mode = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_pick == c_ID_W'(i)) begin
            w_pick_mode = bus.req_mode[i*MODE_W +: MODE_W];
         end
      end
   end

`ifdef CTRL_ARB_TIMEOUT_EN
   assign w_to_hit = (r_hold == c_HOLD_W'(MAX_HOLD - 1));
`else
   assign w_to_hit = 1'b0;
`endif

   assign w_rel = (!bus.req[r_gnt_id] && (r_hold >= c_HOLD_W'(MIN_HOLD - 1))) || w_to_hit;

   always_comb begin
      w_state_nxt  = r_state;
      w_gnt_nxt    = r_gnt;
      w_gnt_id_nxt = r_gnt_id;
      w_last_nxt   = r_last;
      w_enable_nxt = r_enable;
      w_mode_nxt   = r_mode;
      w_hold_nxt   = r_hold;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
`ifdef CTRL_ARB_TIMEOUT_EN
      w_timeout_nxt = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_nxt  = ST_SETUP;
               w_gnt_nxt    = N_REQ'(1) << w_pick;
               w_gnt_id_nxt = w_pick;
               w_last_nxt   = w_pick;
               w_mode_nxt   = w_pick_mode;
               w_enable_nxt = 1'b0;
               w_busy_nxt   = 1'b1;
            end
         end
         ST_SETUP: begin
            w_state_nxt  = ST_ACTIVE;
            w_enable_nxt = 1'b1;
            w_hold_nxt   = '0;
         end
         ST_ACTIVE: begin
            if (w_rel) begin
               w_state_nxt  = ST_RELEASE;
               w_enable_nxt = 1'b0;
               w_gnt_nxt    = '0;
               w_done_nxt   = 1'b1;
`ifdef CTRL_ARB_TIMEOUT_EN
               w_timeout_nxt = w_to_hit;
`endif
            end else if (r_hold != c_HOLD_W'(MAX_HOLD)) begin
               w_hold_nxt = r_hold + 1'b1;
            end
         end
         ST_RELEASE: begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_gnt     <= '0;
         r_gnt_id  <= '0;
         r_last    <= c_ID_W'(N_REQ - 1);
         r_enable  <= 1'b0;
         r_mode    <= '0;
         r_hold    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
`ifdef CTRL_ARB_TIMEOUT_EN
         r_timeout <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_gnt_id  <= w_gnt_id_nxt;
         r_last    <= w_last_nxt;
         r_enable  <= w_enable_nxt;
         r_mode    <= w_mode_nxt;
         r_hold    <= w_hold_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
`ifdef CTRL_ARB_TIMEOUT_EN
         r_timeout <= w_timeout_nxt;
`endif
      end
   end

   assign bus.gnt         = r_gnt;
   assign bus.gnt_id      = r_gnt_id;
   assign bus.ctrl_enable = r_enable;
   assign bus.ctrl_mode   = r_mode;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
`ifdef CTRL_ARB_TIMEOUT_EN
   assign bus.timeout     = r_timeout;
`else
   assign bus.timeout     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/ctrl_mode_arbiter.md
# ctrl_mode_arbiter

Arbitrates ownership of the shared control interface (enable plus 4-bit mode) among N requesters. Grants one owner at a time with round-robin fairness. Drives the interface with break-before-make sequencing: enable is always deasserted while mode changes. Sits between requesting agents and the control interface instance that fans out to downstream leaf logic.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `MODE_W`, 4: width of the mode field.
- `MIN_HOLD`, 4: minimum number of cycles enable stays high per grant, ≥1.
- `MAX_HOLD`, 64: timeout limit in ACTIVE cycles, > `MIN_HOLD`. Used only with `CTRL_ARB_TIMEOUT_EN`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req` in N_REQ: level request per requester, held high while ownership is wanted.
- `req_mode` in N_REQ*MODE_W: requested mode; slice i = `[i*MODE_W +: MODE_W]`.
- `gnt` out N_REQ: one-hot grant.
- `gnt_id` out $clog2(N_REQ): index of the current or last owner.
- `ctrl_enable` out 1: drives the interface `enable`.
- `ctrl_mode` out MODE_W: drives the interface `mode`.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse in RELEASE.
- `timeout` out 1: one-cycle pulse on forced release.

## Operation
- Reset values: state=IDLE, `gnt`=0, `gnt_id`=0, `ctrl_enable`=0, `ctrl_mode`=0, `busy`=0, `done`=0, `timeout`=0. Round-robin pointer `last`=N_REQ-1.
- **IDLE**: if any `req` bit is high, select the first set bit searching upward from `last`+1 with wrap. Then go to SETUP.
- **SETUP**: one cycle.
  - `gnt[k]`=1, `gnt_id`=k, `last`=k.
  - `ctrl_mode` latches `req_mode[k]`; `ctrl_enable`=0.
  - Go to ACTIVE.
- **ACTIVE**: `ctrl_enable`=1 and `gnt[k]`=1.
  - `hold_cnt` is 0 on the first ACTIVE cycle, increments each cycle, and saturates at `MAX_HOLD`.
  - Exit to RELEASE when `req[k]`==0 and `hold_cnt` ≥ `MIN_HOLD`-1.
  - `req_mode` changes during SETUP or ACTIVE are ignored; `ctrl_mode` stays stable for the whole grant.
- **RELEASE**: one cycle. `ctrl_enable`=0, `gnt`=0, `done`=1, `ctrl_mode` holds its value. Go to IDLE.
- Boundary cases:
  - `req[k]` dropping in SETUP or early in ACTIVE does not shorten the grant; enable stays high exactly `MIN_HOLD` cycles.
  - Requests from other agents during a grant are only evaluated in IDLE.
  - A sole requester that keeps `req` high holds ownership indefinitely (unless the timeout build is used).
  - Reset mid-grant: all outputs return to their reset values asynchronously, including `ctrl_enable`=0 immediately.
- `ctrl_mode` holds its last value after a grant ends. It never changes while `ctrl_enable`=1.

## Timing
- Grant latency: `req` is sampled high in IDLE at cycle t. `gnt` rises at t+1 (SETUP) and `ctrl_enable` rises at t+2.
- Enable-low gap between consecutive owners is exactly 3 cycles: RELEASE, IDLE, SETUP.
- Deassert latency: `req[k]` low at cycle t with the hold satisfied gives `ctrl_enable` low and `done` high at t+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `CTRL_ARB_TIMEOUT_EN` defined:
  - In ACTIVE, when `hold_cnt` reaches `MAX_HOLD`-1, the arbiter goes to RELEASE regardless of `req[k]`.
  - `timeout` pulses in the same cycle as `done`.
  - Enable is therefore high for at most `MAX_HOLD` cycles.
  - Round-robin then advances; a sole requester that is still requesting is re-granted after the 3-cycle gap.
- `CTRL_ARB_TIMEOUT_EN` undefined: no timeout logic, `timeout` is tied to 0, and grants are unbounded.

## Test plan
- **Reset**: assert `rst_n`=0 during ACTIVE. Required: `ctrl_enable`, `gnt`, `busy` go to 0 without waiting for a clock edge; after release, a request to req[0] is granted first.
- **Single request**: req[2]=1 with mode 4'b0001, held 10 cycles. Required: `gnt`=4'b0100 at t+1, `ctrl_mode`=1 at t+1, enable high from t+2, `done` one cycle after req drops.
- **Minimum hold**: req[1] pulsed for 1 cycle. Required: enable high for exactly 4 cycles, then `done` pulses.
- **Round-robin**: req=4'b1111 continuously, each owner drops req after 5 enable cycles. Required: grant order 0,1,2,3,0, with a 3-cycle enable-low gap between owners.
- **Mode stability**: `req_mode[0]` toggles 4'b0001↔4'b1000 every cycle during the grant. Required: `ctrl_mode` constant at the value latched in SETUP.
- **Timeout** (macro defined, `MAX_HOLD`=64): req[3] held forever. Required: enable high for exactly 64 cycles, `timeout` and `done` pulse together, re-grant after 3 cycles.
